// File: rtl/fsm_debounce_pkg.sv
// Shared definitions for the debounce input stage: state encoding and
// the default qualification length used in simulation.
package fsm_debounce_pkg;

  typedef enum logic [1:0] {
    LO_STABLE = 2'd0,
    LO_WAIT   = 2'd1,
    HI_STABLE = 2'd2,
    HI_WAIT   = 2'd3
  } state_e;

  // Simulation-friendly default; silicon builds override to ~1e6.
  localparam int DEFAULT_STABLE_CYC = 4;

endpackage

// File: rtl/fsm_debounce_if.sv
// Level-input bundle for the debounce stage: raw input in, clean level
// and qualification flag out.
interface fsm_debounce_if;

  logic din;
  logic dout;
  logic busy;

  modport master (output din, input dout, input busy);
  modport slave  (input din, output dout, output busy);

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level. Synchronous
// active-low reset clears both stages to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic s1_q, s2_q;

  // Shift the raw level through two flops to settle metastability.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/fsm_debounce.sv
// Debounce stage: synchronises a bouncy level and only lets a change
// through after STABLE_CYC+1 consecutive synchronised samples agree.
// Outputs are decoded from the state register alone so they never glitch.
module fsm_debounce
  import fsm_debounce_pkg::*;
#(
  parameter int STABLE_CYC = DEFAULT_STABLE_CYC
) (
  input  logic          clk,
  input  logic          rst,
  fsm_debounce_if.slave bus
);

  localparam int CNT_W = $clog2(STABLE_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYC - 1);

  logic             s_in;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The raw input reaches the FSM only through the synchroniser.
  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.din),
    .q_o (s_in)
  );

  // State and counter registers; reset wins over any qualification in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= LO_STABLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter logic; counter is 0 unless a WAIT state advances it.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      LO_STABLE: begin
        if (s_in) state_d = LO_WAIT;
      end
      LO_WAIT: begin
        if (!s_in)                 state_d = LO_STABLE;
        else if (cnt_q == CNT_LAST) state_d = HI_STABLE;
        else                        cnt_d   = cnt_q + 1'b1;
      end
      HI_STABLE: begin
        if (!s_in) state_d = HI_WAIT;
      end
      HI_WAIT: begin
        if (s_in)                   state_d = HI_STABLE;
        else if (cnt_q == CNT_LAST) state_d = LO_STABLE;
        else                        cnt_d   = cnt_q + 1'b1;
      end
      default: begin
        state_d = LO_STABLE;
      end
    endcase
  end

  assign bus.dout = (state_q == HI_STABLE) || (state_q == HI_WAIT);
  assign bus.busy = (state_q == LO_WAIT)   || (state_q == HI_WAIT);

endmodule

// File: tb/tb_fsm_debounce.sv
// Bench for fsm_debounce with STABLE_CYC=4: table of per-edge vectors with
// hand-derived expectations fed through a scoreboard queue, plus hand
// sequences for reset during HI_WAIT and a downstream dual-edge detector.
module tb_fsm_debounce;

  typedef struct {
    logic  rst;
    logic  din;
    logic  exp_dout;
    logic  exp_busy;
    string tag;
  } vec_t;

  typedef struct {
    logic  dout;
    logic  busy;
    string tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  vec_t tbl[$];
  exp_t sb[$];

  fsm_debounce_if bus ();

  fsm_debounce #(.STABLE_CYC(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Downstream dual-edge detector model: one-cycle pulse per dout change.
  logic det_q = 1'b0;
  always @(posedge clk) det_q <= bus.dout;
  wire det_pulse = bus.dout ^ det_q;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t, required < 200000", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input string tag, input logic r, input logic d, input logic ed, input logic eb);
    vec_t v;
    v.rst = r; v.din = d; v.exp_dout = ed; v.exp_busy = eb; v.tag = tag;
    tbl.push_back(v);
  endtask

  // Add one segment: din pattern with expected dout/busy per edge (bit 0 first edge).
  task automatic add_seq(input string tag, input int n, input logic r,
                         input logic [31:0] d, input logic [31:0] ed, input logic [31:0] eb);
    for (int i = 0; i < n; i++) add($sformatf("%s[%0d]", tag, i), r, d[i], ed[i], eb[i]);
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    rst     = v.rst;
    bus.din = v.din;
    e.dout = v.exp_dout; e.busy = v.exp_busy; e.tag = v.tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty, got 0 entries, expected 1", v.tag);
    end else begin
      e = sb.pop_front();
      check({e.tag, ".dout"}, {31'd0, bus.dout}, {31'd0, e.dout});
      check({e.tag, ".busy"}, {31'd0, bus.busy}, {31'd0, e.busy});
    end
  endtask

  task automatic drive(input logic r, input logic d);
    @(negedge clk);
    rst     = r;
    bus.din = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.din = 1'b1;

    // Reset with din=1, then release: busy from edge 3, dout on edge 7.
    add_seq("rst_hold", 3, 1'b0, 32'b111, 32'b000, 32'b000);
    add_seq("rst_rel", 9, 1'b1, 32'b1_1111_1111, 32'b1_1100_0000, 32'b0_0011_1100);
    // Falling qualification from HI_STABLE.
    add_seq("fall", 8, 1'b1, 32'b0000_0000, 32'b0011_1111, 32'b0011_1100);
    // 4-cycle pulse rejected.
    add_seq("rej4", 8, 1'b1, 32'b0000_1111, 32'b0000_0000, 32'b0011_1100);
    // 5-cycle pulse accepted on edge 7, then held.
    add_seq("acc5", 8, 1'b1, 32'b1111_1111, 32'b1100_0000, 32'b0011_1100);
    // Blip during HI_WAIT restarts the count; fall completes 5 samples later.
    add_seq("hiblip", 11, 1'b1, 32'b000_0000_1000, 32'b011_1111_1111, 32'b011_1101_1100);
    // Bounce burst 1,0,1,1,0,1 then steady 1: one rise, 7 edges after last 0->1.
    add_seq("burst", 14, 1'b1, 32'b11_1111_1110_1101, 32'b11_1000_0000_0000, 32'b00_0111_1011_0100);
    // din toggling each cycle from HI: dout stays 1, busy toggles.
    add_seq("toggle", 11, 1'b1, 32'b111_1010_1010, 32'b111_1111_1111, 32'b001_0101_0100);

    foreach (tbl[i]) apply(tbl[i]);

    // Reset during HI_WAIT with cnt=2.
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0);
    check("midrst.pre_state", {30'd0, dut.state_q}, 32'd3);
    check("midrst.pre_cnt",   {30'd0, dut.cnt_q},   32'd2);
    check("midrst.pre_dout",  {31'd0, bus.dout},    32'd1);
    drive(1'b0, 1'b0);
    check("midrst.dout",  {31'd0, bus.dout},    32'd0);
    check("midrst.busy",  {31'd0, bus.busy},    32'd0);
    check("midrst.state", {30'd0, dut.state_q}, 32'd0);
    check("midrst.cnt",   {30'd0, dut.cnt_q},   32'd0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0);
    check("midrst.after", {31'd0, bus.dout}, 32'd0);

    // Chain: bounce on press and release -> exactly two single-cycle pulses.
    begin
      logic [5:0] press   = 6'b101101;
      logic [5:0] release_ = 6'b010010;
      int pulses = 0;
      int pulse_cyc = 0;
      logic prev = 1'b0;
      for (int i = 0; i < 22; i++) begin
        drive(1'b1, (i < 6) ? press[i] : 1'b1);
        pulse_cyc += int'(det_pulse);
        if (det_pulse && !prev) pulses++;
        prev = det_pulse;
      end
      check("chain.hi", {31'd0, bus.dout}, 32'd1);
      for (int i = 0; i < 22; i++) begin
        drive(1'b1, (i < 6) ? release_[i] : 1'b0);
        pulse_cyc += int'(det_pulse);
        if (det_pulse && !prev) pulses++;
        prev = det_pulse;
      end
      check("chain.lo",        {31'd0, bus.dout}, 32'd0);
      check("chain.pulses",    pulses,    32'd2);
      check("chain.pulse_cyc", pulse_cyc, 32'd2);
    end

    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsm_debounce.md
Name: fsm_debounce

Overview:
- Input-conditioning stage placed directly upstream of the dual-edge detector FSM.
- Synchronises an asynchronous, bouncy level input (button, switch, external strobe) into the clock domain.
- Passes a level change on only after the input has stayed at the new value for a programmable number of consecutive cycles.
- The downstream edge detector therefore sees one clean transition per physical event.

Parameters:
- STABLE_CYC, 4, number of consecutive wait-state cycles the synchronised input must hold before the output follows. Legal range is 2 or more; sims use 4, silicon uses about 1e6.
- CNT_W, $clog2(STABLE_CYC), counter width. Derived localparam, not overridable.

Ports:
- clk  input  1  single system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-low reset, sampled on the clk rising edge.
- din  input  1  raw asynchronous level input (may bounce or glitch).
- dout  output  1  debounced, registered level; feeds the edge detector's din.
- busy  output  1  high while a candidate transition is being qualified (either WAIT state).

Behaviour:
- Reset:
  - rst=0 at a clk edge forces sync flops to 0, state to LO_STABLE, cnt to 0, dout to 0, busy to 0.
  - rst has priority over all other events, including mid-qualification.
- Synchroniser:
  - Two flops: din -> s1 -> s_in.
  - s_in is valid 2 edges after din is first sampled.
  - No other logic may use din directly.
- States (2-bit): LO_STABLE=0, LO_WAIT=1, HI_STABLE=2, HI_WAIT=3.
  - dout = 1 in HI_STABLE and HI_WAIT.
  - busy = 1 in LO_WAIT and HI_WAIT.
  - Both outputs are decoded from the state register only (Moore, glitch-free).
- Transitions, evaluated each edge with rst=1:
  - LO_STABLE: s_in=1 -> LO_WAIT with cnt=0; else stay.
  - LO_WAIT, s_in=0: -> LO_STABLE, cnt=0 (glitch rejected, dout unchanged).
  - LO_WAIT, s_in=1, cnt==STABLE_CYC-1: -> HI_STABLE, cnt=0.
  - LO_WAIT, s_in=1, otherwise: cnt++.
  - HI_STABLE: s_in=0 -> HI_WAIT with cnt=0; else stay.
  - HI_WAIT: mirror of LO_WAIT with s_in polarity inverted. Success -> LO_STABLE; revert -> HI_STABLE.
  - Illegal/default state -> LO_STABLE, cnt=0.
- Latency:
  - s_in must be at the new value for STABLE_CYC+1 consecutive samples.
  - Count edge 1 as the first edge that samples a new din value. dout changes on edge STABLE_CYC+3 (edge 7 for STABLE_CYC=4).
  - busy rises on edge 3 and falls on the same edge that dout changes.
- Counter:
  - Unsigned, CNT_W bits, never exceeds STABLE_CYC-1, so no wrap.
  - Held at 0 in both STABLE states.
- Boundary conditions:
  - din held exactly STABLE_CYC+1 cycles -> accepted.
  - din held STABLE_CYC cycles -> rejected.
  - Bounce inside a WAIT state restarts qualification from the STABLE state (no partial credit).
  - din toggling every cycle -> dout never changes, and busy toggles.
  - Reset released with din=1 -> normal LO->HI qualification; dout rises on edge STABLE_CYC+3 after release.

Decomposition:
- Shared package fsm_pkg holds:
  - the 2-bit state localparams LO_STABLE, LO_WAIT, HI_STABLE, HI_WAIT;
  - a helper constant for the default STABLE_CYC.
- One natural sub-module, sync_2ff: a two-flop synchroniser with synchronous active-low reset clearing to 0.
  - Reusable by other input stages.
- The FSM and counter stay in fsm_debounce.

Test Plan (all STABLE_CYC=4):
- Reset: hold rst=0 for 3 edges with din=1 -> dout=0, busy=0. Release with din=1 held -> busy=1 from edge 3, dout=1 on edge 7, busy=0 on edge 7.
- Glitch rejection: from LO_STABLE, din=1 for exactly 4 cycles then 0 -> dout stays 0, busy pulses high then returns to 0. Repeat with 5 cycles -> dout=1.
- Falling qualification: from HI_STABLE, din=0 held -> dout=0 on edge 7. A 1-cycle din=1 blip during HI_WAIT -> dout stays 1 and the count restarts.
- Bounce burst: din pattern 1,0,1,1,0,1 followed by steady 1 -> exactly one dout 0->1 transition, occurring 7 edges after the final 0->1 din change.
- Reset mid-operation: rst=0 asserted while in HI_WAIT with cnt=2 -> next edge dout=0, busy=0, state=LO_STABLE, cnt=0.
- Chain check: instantiate ahead of the dual-edge detector, drive the bounce burst on press and on release -> detector dout shows exactly two single-cycle pulses.
